rdw_stage: RTL and testbench

- Read-data-wait pipeline stage between the MEM stage (issues data-bus requests) and the WB stage (consumes `data_from_RDW`).
- Holds one instruction, waits for the data-bus response (`data_ok`) of its load and captures `rdata`.
- Forwards the instruction to WB with a valid/ready handshake.
- Tracks responses orphaned by a pipeline flush and discards them, so a stale response is never attributed to a younger load.

---
 rtl/rdw_stage.sv | 200 ++++++++++++++++++++
 tb/tb_rdw_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rdw_stage.sv
// ---------------------------------------------------------------------------
// rdw_stage : read-data-wait pipeline stage between MEM and WB.
//
// Holds one instruction, waits for the data-bus response (data_ok) of the
// request that instruction issued, captures rdata and hands the instruction
// to WB through a valid/ready handshake. Responses belonging to instructions
// killed by a WB flush are counted in discard_cnt and silently dropped when
// they come back, so a stale response is never credited to a younger load.
//
// Optional feature (macro RDW_DATA_BYPASS_EN):
//   When defined, a usable data_ok arriving in WAIT raises out_valid in the
//   same cycle and drives data_from_RDW straight from rdata. If WB is ready,
//   the occupant leaves without visiting HOLD. When undefined, the stage is
//   a pure registered path and out_valid follows the state register.
//
// Parameters:
//   PAYLOAD_W     width of the opaque side-band bundle passed through
//   CNT_W         width of the orphaned-response discard counter
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-high reset
//   in_valid      MEM stage presents an instruction
//   in_ready      this stage can accept this cycle
//   in_req_sent   entering instruction issued a data-bus request
//   in_payload    side-band bundle of the entering instruction
//   data_ok       data-bus response strobe (one per request, in order)
//   rdata         response data, valid with data_ok
//   flush         WB flush, kills the occupant and the entering instruction
//   out_valid     instruction ready for WB
//   out_ready     WB can accept
//   out_payload   registered side-band bundle
//   data_from_RDW load data for WB
//   rdw_wait      occupant is still waiting for its response
// ---------------------------------------------------------------------------
module rdw_stage #(
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_req_sent,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 data_ok,
  input  logic [31:0]          rdata,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          data_from_RDW,
  output logic                 rdw_wait
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // One extra bit so an overflow of the discard counter is visible to the
  // check below instead of silently wrapping.
  typedef logic [CNT_W:0] cnt_wide_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     discard_cnt;
  logic [CNT_W-1:0]     cnt_next;
  cnt_wide_t            cnt_wide;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [31:0]          data_q;

  logic resp_use;
  logic resp_drop;
  logic accept;
  logic capture;
  logic bypass_fire;
  logic bypass_leave;
  logic inc_wait_kill;
  logic inc_mem_kill;

  // Response attribution: while orphans are outstanding, every data_ok
  // belongs to a killed instruction and is dropped.
  always_comb begin
    resp_drop = data_ok & (discard_cnt != '0);
    resp_use  = data_ok & (discard_cnt == '0);
  end

  // Handshake towards MEM. A flush blocks acceptance outright because the
  // instruction MEM is presenting is being killed as well.
  always_comb begin
    in_ready = ~rst & ~flush & ((state == ST_EMPTY) | ((state == ST_HOLD) & out_ready));
    accept   = in_valid & in_ready;
  end

  // A usable response is captured for the WAIT occupant or for a request
  // instruction entering this very cycle. Nothing is captured under flush,
  // since its owner is being killed anyway.
  always_comb begin
    capture = ~flush & resp_use & ((state == ST_WAIT) | (accept & in_req_sent));
  end

`ifdef RDW_DATA_BYPASS_EN
  // Same-cycle forwarding of the response to WB.
  always_comb begin
    bypass_fire   = ~flush & resp_use & (state == ST_WAIT);
    bypass_leave  = bypass_fire & out_ready;
    data_from_RDW = bypass_fire ? rdata : data_q;
  end
`else
  always_comb begin
    bypass_fire   = 1'b0;
    bypass_leave  = 1'b0;
    data_from_RDW = data_q;
  end
`endif

  // Outputs towards WB. The occupant is invisible to WB in a flush cycle.
  always_comb begin
    out_valid   = ~flush & ((state == ST_HOLD) | bypass_fire);
    out_payload = payload_q;
    rdw_wait    = (state == ST_WAIT);
  end

  // Next-state logic. Flush wins over everything; otherwise the occupant
  // progresses first and an accept in the same cycle overrides the result,
  // which covers the HOLD-drain-and-refill case.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (resp_use) begin
            state_next = bypass_leave ? ST_EMPTY : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
      if (accept) begin
        state_next = (in_req_sent & ~resp_use) ? ST_WAIT : ST_HOLD;
      end
    end
  end

  // Discard counter bookkeeping. A flush orphans the WAIT occupant's request
  // (unless its response arrives in the same cycle) and the request of the
  // MEM instruction being killed; each dropped response retires one orphan.
  always_comb begin
    inc_wait_kill = flush & (state == ST_WAIT) & ~resp_use;
    inc_mem_kill  = flush & in_valid & in_req_sent;
    cnt_wide      = {1'b0, discard_cnt}
                  + cnt_wide_t'(inc_wait_kill)
                  + cnt_wide_t'(inc_mem_kill)
                  - cnt_wide_t'(resp_drop);
    cnt_next      = cnt_wide[CNT_W-1:0];
  end

  // State, counter and captured data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      discard_cnt <= '0;
      payload_q   <= '0;
      data_q      <= '0;
    end else begin
      state       <= state_next;
      discard_cnt <= cnt_next;
      if (accept) begin
        payload_q <= in_payload;
      end
      if (capture) begin
        data_q <= rdata;
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: a usable response must have an owner, and the discard
  // counter must never reach its all-ones value (bus depth rules it out).
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_use & (state != ST_WAIT) & ~(accept & in_req_sent)))
        else $error("rdw_stage: data_ok with no outstanding request");
      assert (cnt_wide < cnt_wide_t'((1 << CNT_W) - 1))
        else $error("rdw_stage: discard counter overflow");
    end
  end
`endif

endmodule

// File: tb/tb_rdw_stage.sv
// ---------------------------------------------------------------------------
// tb_rdw_stage : self-checking bench for rdw_stage.
//
// The reference model tracks the stage as one occupant record plus a FIFO
// of outstanding bus requests, each tagged live or orphaned. Responses pop
// the FIFO in order; only a live entry delivers data. Directed steps cover
// the main scenarios, followed by a randomized protocol-legal phase.
// ---------------------------------------------------------------------------
module tb_rdw_stage;

  localparam int PW = 160;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_req_sent;
  logic [PW-1:0] in_payload;
  logic          data_ok;
  logic [31:0]   rdata;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [31:0]   data_from_RDW;
  logic          rdw_wait;

  int tests = 0;
  int fails = 0;

  rdw_stage #(
    .PAYLOAD_W(PW),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_req_sent(in_req_sent),
    .in_payload(in_payload),
    .data_ok(data_ok),
    .rdata(rdata),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_payload(out_payload),
    .data_from_RDW(data_from_RDW),
    .rdw_wait(rdw_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef enum int {OCC_NONE, OCC_WAIT, OCC_READY} occ_e;
  occ_e          occ;
  logic          occ_req;
  logic [PW-1:0] occ_payload;
  logic [31:0]   occ_data;
  bit            pending[$];

  function automatic int orphans();
    int n = 0;
    foreach (pending[i]) n += int'(pending[i]);
    return n;
  endfunction

  function automatic void resetModel();
    occ         = OCC_NONE;
    occ_req     = 1'b0;
    occ_payload = '0;
    occ_data    = '0;
    pending.delete();
  endfunction

  function automatic logic [PW-1:0] randPayload();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model at the rising edge.
  task automatic applyStimulus(input logic v, input logic req, input logic [PW-1:0] pl,
                               input logic dok, input logic [31:0] rd, input logic fl,
                               input logic ordy);
    logic exp_in_ready;
    logic acc;
    logic live;
    logic byp;
    logic exp_out_valid;
    @(negedge clk);
    in_valid    = v;
    in_req_sent = req;
    in_payload  = pl;
    data_ok     = dok;
    rdata       = rd;
    flush       = fl;
    out_ready   = ordy;
    #1;
    exp_in_ready = !fl && (occ == OCC_NONE || (occ == OCC_READY && ordy));
    acc          = v && exp_in_ready;
    if (!dok)                    live = 1'b0;
    else if (pending.size() > 0) live = (pending[0] == 1'b0);
    else                         live = acc && req;
    byp = 1'b0;
`ifdef RDW_DATA_BYPASS_EN
    byp = !fl && live && (occ == OCC_WAIT);
`endif
    exp_out_valid = !fl && (occ == OCC_READY || byp);
    checkOutput("in_ready", PW'(in_ready), PW'(exp_in_ready));
    checkOutput("out_valid", PW'(out_valid), PW'(exp_out_valid));
    checkOutput("rdw_wait", PW'(rdw_wait), PW'(occ == OCC_WAIT));
    if (exp_out_valid) begin
      checkOutput("out_payload", out_payload, occ_payload);
      if (occ_req) checkOutput("data_from_RDW", PW'(data_from_RDW), PW'(byp ? rd : occ_data));
    end
    @(posedge clk);
    if (acc && req) pending.push_back(1'b0);
    if (dok && pending.size() > 0) void'(pending.pop_front());
    if (fl) begin
      foreach (pending[i]) pending[i] = 1'b1;
      if (v && req) pending.push_back(1'b1);
      occ = OCC_NONE;
    end else begin
      if (occ == OCC_WAIT && live) begin
        occ_data = rd;
        occ      = (byp && ordy) ? OCC_NONE : OCC_READY;
      end else if (occ == OCC_READY && ordy) begin
        occ = OCC_NONE;
      end
      if (acc) begin
        occ_payload = pl;
        occ_req     = req;
        if (req && !live) begin
          occ = OCC_WAIT;
        end else begin
          occ = OCC_READY;
          if (req) occ_data = rd;
        end
      end
    end
  endtask

  initial begin
    logic          r_v, r_req, r_dok, r_fl, r_ordy, r_ir, r_acc;
    logic [PW-1:0] a5;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_req_sent = 1'b0;
    in_payload  = '0;
    data_ok     = 1'b0;
    rdata       = 32'h0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    resetModel();
    #1;
    checkOutput("reset_out_valid", PW'(out_valid), '0);
    checkOutput("reset_in_ready", PW'(in_ready), '0);
    checkOutput("reset_rdw_wait", PW'(rdw_wait), '0);
    checkOutput("reset_payload", out_payload, '0);
    checkOutput("reset_data", PW'(data_from_RDW), '0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back non-request instructions
    a5 = {5{32'hA5A5A5A5}};
    applyStimulus(1'b1, 1'b0, a5, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, ~a5, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, a5 ^ PW'(1), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Load with data_ok three cycles after accept
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("load_data", PW'(data_from_RDW), PW'(32'hDEADBEEF));

    // Load held while WB stalls for four cycles, then drains
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    a5 = randPayload();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, a5, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, a5, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush in WAIT with a request-issuing MEM instruction: two orphans
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h3, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("orphan_drop_data", PW'(data_from_RDW), PW'(32'h3));

    // Flush coinciding with a usable response: nothing is orphaned
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h55, 1'b1, 1'b1);
    #1;
    checkOutput("flush_resp_valid", PW'(out_valid), '0);
    checkOutput("flush_resp_wait", PW'(rdw_wait), '0);
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h77, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1'b1, 1'b1, randPayload(), 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("pre_reset_wait", PW'(rdw_wait), PW'(1'b1));
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", PW'(out_valid), '0);
    checkOutput("async_rst_wait", PW'(rdw_wait), '0);
    checkOutput("async_rst_data", PW'(data_from_RDW), '0);
    checkOutput("async_rst_payload", out_payload, '0);
    checkOutput("async_rst_in_ready", PW'(in_ready), '0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_in_ready", PW'(in_ready), '0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    // Randomized, protocol-legal traffic
    for (int n = 0; n < 500; n++) begin
      r_ordy = ($urandom % 4) != 0;
      r_fl   = (($urandom % 12) == 0) && (orphans() == 0);
      r_v    = $urandom % 2;
      r_req  = $urandom % 2;
      r_ir   = !r_fl && (occ == OCC_NONE || (occ == OCC_READY && r_ordy));
      r_acc  = r_v && r_ir;
      r_dok  = (pending.size() > 0 || (r_acc && r_req)) && (($urandom % 2) == 0);
      applyStimulus(r_v, r_req, randPayload(), r_dok, $urandom, r_fl, r_ordy);
    end
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
